// File: rtl/uart_load_ctrl.sv
// -----------------------------------------------------------------------------
// uart_load_ctrl
//
// Write-clock-domain sequencer for the UART program-load path. It parses the
// framed byte stream coming from the UART receiver:
//
//   SYNC_BYTE, LEN (words, 1..255), 2*LEN payload bytes, CHK (XOR of payload)
//
// Only payload bytes are forwarded to the dual-clock byte FIFO. After the
// checksum byte, the block waits for the FIFO (and the BRAM packer behind it)
// to drain. It then releases the CPU from hold, but only if the frame was
// clean.
//
// Ports:
//   i_clk_wr       100 MHz UART-domain clock
//   i_rst_n        asynchronous active-low reset
//   i_rx_valid     one-cycle strobe, new UART byte on i_rx_data
//   i_rx_data      UART byte
//   i_fifo_empty   FIFO empty flag (already in the i_clk_wr domain)
//   o_valid_uart   FIFO write strobe (one cycle per payload byte)
//   o_data_uart    FIFO write data
//   o_cpu_hold     1 = CPU held in reset
//   o_load_done    one-cycle pulse on a successful load
//   o_err_checksum sticky: checksum mismatch
//   o_err_timeout  sticky: inter-byte timeout inside a frame
//   o_err_len      sticky: length byte was zero
//   o_state        current state encoding (debug)
// -----------------------------------------------------------------------------
module uart_load_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         DRAIN_CYCLES   = 8
) (
  input  logic       i_clk_wr,
  input  logic       i_rst_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  input  logic       i_fifo_empty,
  output logic       o_valid_uart,
  output logic [7:0] o_data_uart,
  output logic       o_cpu_hold,
  output logic       o_load_done,
  output logic       o_err_checksum,
  output logic       o_err_timeout,
  output logic       o_err_len,
  output logic [2:0] o_state
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CKSUM   = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic [2:0]       state;
  logic [8:0]       byte_cnt;
  logic [7:0]       xor_acc;
  logic [TMO_W-1:0] tmo_cnt;
  logic [DRN_W-1:0] drn_cnt;
  logic             in_frame;
  logic             any_err;

  // The timeout watchdog is only armed while bytes of a frame are expected.
  assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) ||
                    (state == ST_CKSUM);
  assign any_err  = o_err_checksum | o_err_timeout | o_err_len;
  assign o_state  = state;

  always_ff @(posedge i_clk_wr or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      byte_cnt       <= '0;
      xor_acc        <= '0;
      tmo_cnt        <= '0;
      drn_cnt        <= '0;
      o_valid_uart   <= 1'b0;
      o_data_uart    <= '0;
      o_cpu_hold     <= 1'b1;
      o_load_done    <= 1'b0;
      o_err_checksum <= 1'b0;
      o_err_timeout  <= 1'b0;
      o_err_len      <= 1'b0;
    end else begin
      // Strobes default low so each is high for exactly one cycle.
      o_valid_uart <= 1'b0;
      o_load_done  <= 1'b0;

      if (in_frame && !i_rx_valid) begin
        // Silent cycle inside a frame: advance the watchdog and abandon the
        // frame when it expires. Bytes already written stay in the FIFO and
        // the CPU stays held.
        if (tmo_cnt == TMO_LAST) begin
          o_err_timeout <= 1'b1;
          state         <= ST_IDLE;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_ONE;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
              o_err_checksum <= 1'b0;
              o_err_timeout  <= 1'b0;
              o_err_len      <= 1'b0;
              o_cpu_hold     <= 1'b1;
              tmo_cnt        <= '0;
              state          <= ST_LEN;
            end
          end

          ST_LEN: begin
            tmo_cnt <= '0;
            if (i_rx_data == 8'd0) begin
              o_err_len <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              // LEN counts 16-bit words; the byte counter needs the ninth bit.
              byte_cnt <= {i_rx_data, 1'b0};
              xor_acc  <= '0;
              state    <= ST_PAYLOAD;
            end
          end

          ST_PAYLOAD: begin
            tmo_cnt      <= '0;
            o_valid_uart <= 1'b1;
            o_data_uart  <= i_rx_data;
            xor_acc      <= xor_acc ^ i_rx_data;
            byte_cnt     <= byte_cnt - 9'd1;
            if (byte_cnt == 9'd1) begin
              state <= ST_CKSUM;
            end
          end

          ST_CKSUM: begin
            tmo_cnt <= '0;
            if (i_rx_data != xor_acc) begin
              o_err_checksum <= 1'b1;
            end
            drn_cnt <= '0;
            state   <= ST_DRAIN;
          end

          ST_DRAIN: begin
            // Need DRAIN_CYCLES consecutive empty cycles, so the packer
            // downstream of the FIFO has flushed its last word.
            if (!i_fifo_empty) begin
              drn_cnt <= '0;
            end else if (drn_cnt == DRN_LAST) begin
              state <= ST_DONE;
              // The pulse is registered here so it lines up with DONE.
              if (!any_err) begin
                o_load_done <= 1'b1;
                o_cpu_hold  <= 1'b0;
              end
            end else begin
              drn_cnt <= drn_cnt + DRN_ONE;
            end
          end

          ST_DONE: begin
            state <= ST_IDLE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_load_ctrl.md
Name: uart_load_ctrl

Overview:
- Write-clock-domain (100 MHz) sequencer for the UART program-load path.
- Parses a framed byte stream from the UART receiver, forwards only payload bytes into the dual-clock byte FIFO, and validates the frame.
- Waits for the FIFO and BRAM packer to drain, then releases the CPU from hold.
- Sits between the UART receiver and the FIFO write port; its hold output gates CPU reset.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, max i_clk_wr cycles between consecutive bytes inside a frame (10 ms).
- DRAIN_CYCLES, 8, i_clk_wr cycles to wait after FIFO reports empty before declaring done.

Ports:
- i_clk_wr  input  1  100 MHz UART-domain clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_rx_valid  input  1  one-cycle strobe, new UART byte.
- i_rx_data  input  8  UART byte, valid with i_rx_valid.
- i_fifo_empty  input  1  FIFO empty flag, already in i_clk_wr domain.
- o_valid_uart  output  1  FIFO write strobe.
- o_data_uart  output  8  FIFO write data.
- o_cpu_hold  output  1  1 = CPU held in reset.
- o_load_done  output  1  one-cycle pulse, successful load.
- o_err_checksum  output  1  sticky, checksum mismatch.
- o_err_timeout  output  1  sticky, inter-byte timeout.
- o_err_len  output  1  sticky, length byte was 0.
- o_state  output  3  current state encoding, for debug.

Behaviour:
- Reset: all outputs 0 except o_cpu_hold=1. State=IDLE, counters and checksum accumulator cleared. Reset mid-frame aborts immediately; no partial strobe.
- Frame format: SYNC_BYTE, LEN (words, 1..255), 2*LEN payload bytes, CHK. CHK = XOR of all payload bytes.
- States and transitions:
  - IDLE(0): wait for i_rx_valid with data==SYNC_BYTE. Other bytes ignored. On sync: clear all three error flags, set o_cpu_hold=1, go to LEN.
  - LEN(1): next byte is the length. If 0: set o_err_len, go to IDLE. Otherwise load byte counter = 2*LEN (9 bits), clear XOR accumulator, go to PAYLOAD.
  - PAYLOAD(2): each byte is registered to o_data_uart with o_valid_uart=1 for exactly one cycle, the cycle after i_rx_valid (latency 1). Each byte is XORed into the accumulator and decrements the counter. When the counter reaches 0 after a byte, go to CKSUM.
  - CKSUM(3): on the next byte, compare it with the accumulator. Mismatch sets o_err_checksum. Either way go to DRAIN.
  - DRAIN(4): wait for i_fifo_empty=1, then count DRAIN_CYCLES consecutive cycles. If empty deasserts, restart the count. At terminal count go to DONE.
  - DONE(5): one cycle. If no error, pulse o_load_done and set o_cpu_hold=0. Go to IDLE.
- Timeout: an i_clk_wr cycle counter runs in LEN, PAYLOAD and CKSUM, reset by every i_rx_valid. Reaching TIMEOUT_CYCLES sets o_err_timeout and goes to IDLE. o_cpu_hold stays 1. Bytes already written remain in the FIFO.
- o_cpu_hold: cleared only in DONE without error; set again only on a new sync byte in IDLE.
- In DRAIN and DONE, i_rx_valid is ignored (not forwarded, not counted).
- Flow control: no FIFO full input exists. UART byte rate (≤1 byte/1000 cycles) is far below FIFO drain rate, so overflow cannot occur by construction.
- An odd payload count cannot arise, since the count is always 2*LEN.
- o_valid_uart is never asserted outside PAYLOAD plus its one-cycle registered tail.
- Counter widths: byte counter 9 bits; timeout counter clog2(TIMEOUT_CYCLES+1); drain counter clog2(DRAIN_CYCLES+1).

Test Plan:
- Nominal load: A5,02,12,34,56,78,CHK=0x08 → four o_valid_uart pulses with 12,34,56,78, each 1 cycle after its rx strobe. After empty plus 8 cycles: o_load_done pulse, o_cpu_hold 1→0, no error flags.
- Checksum error: same frame with CHK=0x09 → payload still forwarded. After drain, o_err_checksum=1, no o_load_done, o_cpu_hold stays 1.
- Garbage and zero length: 00,FF,A5,00 → no writes; o_err_len=1; state back to IDLE. A following valid frame clears o_err_len on its sync byte and completes.
- Timeout: A5,01,AA then silence for 1000000 cycles → o_err_timeout=1, state IDLE, o_cpu_hold=1. A subsequent valid frame completes normally.
- Drain hold-off: keep i_fifo_empty=0 for 50 cycles after CHK, pulse it low once during the count → o_load_done occurs exactly 8 cycles after the last empty rise.
- Reset mid-payload: assert i_rst_n low after 3 payload bytes → outputs at reset values immediately. A fresh frame after release loads correctly.
